// File: rtl/fpu_issue_pkg.sv
// rtl/fpu_issue_pkg.sv - shared op codes, instruction field layout and FP classification masks
package fpu_issue_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [1:0]  FP_MAJOR = 2'b11;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 30;
  localparam int RS1_MSB = 29;
  localparam int RS1_LSB = 25;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;
  localparam int MAJ_MSB = 1;
  localparam int MAJ_LSB = 0;

  localparam logic [31:0] EXP_MASK = 32'h7F80_0000;
  localparam logic [31:0] MAN_MASK = 32'h007F_FFFF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic is_nan(input logic [31:0] v);
    return ((v & EXP_MASK) == EXP_MASK) && ((v & MAN_MASK) != 32'h0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return ((v & EXP_MASK) == EXP_MASK) && ((v & MAN_MASK) == 32'h0);
  endfunction

endpackage

// File: rtl/fpu_instr_encoder.sv
// rtl/fpu_instr_encoder.sv - combinational op/rs1/rs2 to 32-bit FP instruction word
module fpu_instr_encoder
  import fpu_issue_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] word
);

  // Unlisted bits [19:2] stay zero from the NOP default.
  always_comb begin
    word                   = NOP_WORD;
    word[OP_MSB:OP_LSB]    = op;
    word[RS1_MSB:RS1_LSB]  = rs1;
    word[RS2_MSB:RS2_LSB]  = rs2;
    word[MAJ_MSB:MAJ_LSB]  = FP_MAJOR;
  end

endmodule

// File: rtl/fpu_issue_sequencer.sv
// rtl/fpu_issue_sequencer.sv - holds an encoded FP instruction for its op latency, then returns the sampled result
module fpu_issue_sequencer
  import fpu_issue_pkg::*;
#(
  parameter int ADDSUB_LAT = 5,
  parameter int MUL_LAT    = 5,
  parameter int DIV_LAT    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  output logic [31:0] instruction,
  input  logic [31:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_op,
  output logic        rsp_nan,
  output logic        rsp_inf,
  output logic        busy
);

  if (ADDSUB_LAT < 1 || ADDSUB_LAT > 255 ||
      MUL_LAT    < 1 || MUL_LAT    > 255 ||
      DIV_LAT    < 1 || DIV_LAT    > 255) begin : g_bad_lat
    $error("fpu_issue_sequencer: latency parameters must lie in 1..255");
  end

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  counter;
  logic [1:0]  op_q;
  logic [31:0] enc_word;
  logic [7:0]  lat_m1;
  logic        accept;

  fpu_instr_encoder u_enc (
    .op   (req_op),
    .rs1  (req_rs1),
    .rs2  (req_rs2),
    .word (enc_word)
  );

  // Counter is preloaded with LAT-1 so the word is visible for exactly LAT cycles.
  always_comb begin
    lat_m1 = 8'(ADDSUB_LAT - 1);
    case (req_op)
      OP_ADD, OP_SUB: lat_m1 = 8'(ADDSUB_LAT - 1);
      OP_MUL:         lat_m1 = 8'(MUL_LAT - 1);
      OP_DIV:         lat_m1 = 8'(DIV_LAT - 1);
      default:        lat_m1 = 8'(ADDSUB_LAT - 1);
    endcase
  end

  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)       state_nxt = WAIT;
      WAIT:    if (counter == 8'd0) state_nxt = RESP;
      RESP:    if (rsp_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= NOP_WORD;
      counter     <= 8'd0;
      op_q        <= 2'b00;
      rsp_data    <= 32'h0;
      rsp_op      <= 2'b00;
      rsp_nan     <= 1'b0;
      rsp_inf     <= 1'b0;
    end else if (accept) begin
      instruction <= enc_word;
      counter     <= lat_m1;
      op_q        <= req_op;
    end else if (state == WAIT) begin
      if (counter == 8'd0) begin
        // Flags come from the same sample as rsp_data, never the live bus later.
        rsp_data    <= result;
        rsp_op      <= op_q;
        rsp_nan     <= is_nan(result);
        rsp_inf     <= is_inf(result);
        instruction <= NOP_WORD;
      end else begin
        counter <= counter - 8'd1;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// tb/tb_fpu_issue_sequencer.sv - scoreboard bench: driver pushes expected responses, monitor pops on handshake
module tb_fpu_issue_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] instruction;
  logic [31:0] result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_op;
  logic        rsp_nan;
  logic        rsp_inf;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int hold_low = 0;
  logic [35:0] exp_q[$];

  fpu_issue_sequencer #(.ADDSUB_LAT(5), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .instruction (instruction),
    .result      (result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_op      (rsp_op),
    .rsp_nan     (rsp_nan),
    .rsp_inf     (rsp_inf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_enc(input int op, input int r1, input int r2);
    logic [31:0] w;
    w = op * 32'h4000_0000 + r1 * 32'h0200_0000 + r2 * 32'h0010_0000 + 32'd3;
    return w;
  endfunction

  function automatic int ref_lat(input int op);
    if (op == 2) return 10;
    return 5;
  endfunction

  function automatic logic [35:0] ref_rsp(input int op, input logic [31:0] v);
    int e;
    int m;
    logic nan;
    logic inf;
    logic [1:0] o;
    e   = int'((v >> 23) & 32'd255);
    m   = int'(v & 32'h007F_FFFF);
    nan = (e == 255) && (m != 0);
    inf = (e == 255) && (m == 0);
    o   = 2'(op);
    return {v, o, nan, inf};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0) begin
        rsp_ready = 1'b0;
        hold_low--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    logic        prev_stall;
    logic [35:0] prev_rsp;
    logic [35:0] cur;
    logic [35:0] e;
    prev_stall = 1'b0;
    prev_rsp   = '0;
    forever begin
      @(negedge clk);
      cur = {rsp_data, rsp_op, rsp_nan, rsp_inf};
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("rsp_stable", {rsp_valid, cur}, {1'b1, prev_rsp});
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: got %0h expected no response", cur);
          end else begin
            e = exp_q.pop_front();
            chk("rsp", cur, e);
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = cur;
      end
    end
  end

  // Called at a negedge; returns at a negedge with the DUT in RESP (or idle after a reset).
  task automatic run_req(input int op, input int r1, input int r2, input logic [31:0] val,
                         input bit bp, input bit do_reset);
    int waited;
    int l;
    logic [31:0] w;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_rs1   = 5'(r1);
    req_rs2   = 5'(r2);
    waited    = 0;
    while (!req_ready && waited < 100) begin
      chk("wait_idle", {instruction, req_ready}, {32'h0, 1'b0});
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_rs1   = 5'($urandom);
    req_rs2   = 5'($urandom);
    l = ref_lat(op);
    w = ref_enc(op, r1, r2);
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      chk("instr_hold", {instruction, req_ready, busy, rsp_valid}, {w, 1'b0, 1'b1, 1'b0});
      if (do_reset && k == 3) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid", {instruction, busy, req_ready, rsp_valid}, {32'h0, 1'b0, 1'b1, 1'b0});
        reset = 1'b0;
        return;
      end
      if (k == l) begin
        result = val;
        exp_q.push_back(ref_rsp(op, val));
        if (bp) hold_low = 5;
      end else begin
        result = $urandom;
      end
    end
    @(negedge clk);
    chk("rsp_turn", {instruction, rsp_valid, req_ready}, {32'h0, 1'b1, 1'b0});
    result = $urandom;
  endtask

  initial begin
    logic [31:0] v;
    int waited;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
    result    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {instruction, req_ready, rsp_valid, rsp_data, rsp_op, rsp_nan, rsp_inf, busy},
        {32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;

    run_req(0, 1, 2, 32'h4040_0000, 1'b0, 1'b0);
    run_req(2, 1, 2, 32'h4040_0000, 1'b0, 1'b0);
    run_req(1, 1, 2, 32'hBF80_0000, 1'b0, 1'b0);
    run_req(3, 1, 2, 32'h4080_0000, 1'b0, 1'b0);
    run_req(0, 3, 4, 32'h7FC0_0000, 1'b0, 1'b0);
    run_req(3, 5, 6, 32'hFF80_0000, 1'b0, 1'b0);
    run_req(1, 7, 8, 32'h0000_0000, 1'b0, 1'b0);
    run_req(0, 31, 31, 32'h7F80_0000, 1'b1, 1'b0);
    run_req(2, 9, 10, 32'h1234_5678, 1'b0, 1'b1);
    run_req(0, 1, 2, 32'h3F80_0000, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v[30:23] = 8'hFF;
        1: v[30:0]  = 31'h7F80_0000;
        default: ;
      endcase
      run_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), v, ($urandom_range(0, 4) == 0), 1'b0);
    end

    req_valid = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
